argmax_classifier: RTL
======================

# argmax_classifier

Downstream of the ten-neuron output layer. Waits for every neuron to assert `done`, captures the ten signed 26-bit scores, and scans them one per clock to find the index of the largest score. Result is the predicted digit class and its score, held with a level `valid` until the next inference starts. It is the final stage of the MNIST inference datapath.

## Interface
- `NUM_CLASSES`, 10, number of neuron scores compared
- `OUTPUT_WIDTH`, 26, score width; signed two's complement, 8 integer bits (incl. sign) and 18 fraction bits
- `CLASS_WIDTH`, 4, index width; must satisfy 2^CLASS_WIDTH ≥ NUM_CLASSES
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  asynchronous reset, active-low; all state clears while `rst`=0
- `IN_SCORES`  input  NUM_CLASSES*OUTPUT_WIDTH  neuron outputs; score k at bits [k*OUTPUT_WIDTH +: OUTPUT_WIDTH]
- `in_done`  input  NUM_CLASSES  per-neuron done flags (level)
- `CLASS`  output  CLASS_WIDTH  index of the maximum score
- `MAX_SCORE`  output  OUTPUT_WIDTH  value of the maximum score
- `valid`  output  1  result valid (level)
- `busy`  output  1  scan in progress

## Operation
- `all_done` = AND of `in_done`. `all_done_q` is its registered copy. A start event is `all_done`=1 and `all_done_q`=0, evaluated every cycle.
- State machine IDLE → SCAN → DONE. DONE returns to SCAN on a start event.
- **IDLE/DONE on start:** latch all of `IN_SCORES` into a score bank. Set best=score0, best_idx=0, idx=1, `valid`=0, `busy`=1, and go to SCAN.
- **SCAN, each cycle:**
  - If signed score[idx] > best (strict), then best=score[idx] and best_idx=idx.
  - If idx==NUM_CLASSES-1, write the final best/best_idx to `MAX_SCORE`/`CLASS`, set `valid`=1 and `busy`=0, and go to DONE. Otherwise idx++.
- Ties resolve to the lowest index, because the compare is strict.
- Comparison is full-width signed. There is no saturation and no truncation.
- The scan uses only the captured bank. Changes to `IN_SCORES` or `in_done` after capture do not affect the result.
- A start event while in SCAN is ignored. `all_done_q` still tracks `all_done`, so that event is lost. To trigger again, `in_done` must drop and rise again.
- `CLASS`/`MAX_SCORE` hold their last result through DONE and through the next SCAN. They update only at scan completion.
- If `all_done` is already 1 at reset release, that is a start event, because `all_done_q` resets to 0.

## Timing
- Reset values: `CLASS`=0, `MAX_SCORE`=0, `valid`=0, `busy`=0. Internal state: IDLE, idx=0, `all_done_q`=0, score bank=0.
- Reset takes effect immediately on `rst` falling (asynchronous), including mid-SCAN. Operation resumes on the first rising edge after `rst`=1.
- Latency, with edge E0 as the capture edge:
  - `busy`=1 and `valid`=0 from E0.
  - Compares occur at E1..E(NUM_CLASSES-1).
  - `valid`=1, `busy`=0 and the result appear after E(NUM_CLASSES-1), i.e. edge E9 for the defaults.
- Throughput: one inference per NUM_CLASSES cycles at most, plus the `in_done` re-arm.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Clear winner.**
  - Stimulus: score7=3.0 (26'h00C0000); all others 0.5 (26'h0020000); then raise all `in_done` at once.
  - Required: `CLASS`=7, `MAX_SCORE`=26'h00C0000, `valid` rises exactly 9 edges after capture, and `busy` is high for edges E0..E8.
- **Signed compare.**
  - Stimulus: all scores -1.0 (26'h3FC0000) except score2=-0.25 (26'h3FF0000).
  - Required: `CLASS`=2 and `MAX_SCORE`=26'h3FF0000. An unsigned compare would produce the wrong result and must fail this test.
- **Tie.**
  - Stimulus: score3=score8=2.0 (26'h0080000); others 0.
  - Required: `CLASS`=3.
- **Partial done, then re-arm.**
  - Stimulus: raise `in_done`=10'h1FF and hold 20 cycles, then raise bit 9.
  - Required: no start and `busy`=0 during the hold; the scan starts on the edge where bit 9 rises.
  - Follow-up: keep `in_done` high after the result. Required: no second start. Then drop and re-raise `in_done` with new scores; required: a new result, with `valid` low during the new SCAN.
- **Reset mid-scan and input change after capture.**
  - Stimulus: start a scan; at E2 change `IN_SCORES` so that score9 is largest.
  - Required: the result still reflects the captured values.
  - Stimulus: start a scan; pull `rst` low at E4.
  - Required: all outputs are 0 without waiting for a clock edge. After release with `in_done` still all high, a new scan starts on the first edge.

Source files
------------

// File: rtl/argmax_classifier.sv
// Captures NUM_CLASSES signed scores when every neuron reports done, then scans one per clock for the maximum.
// Result registered NUM_CLASSES-1 edges after capture; no backpressure, and start events during a scan are dropped.
module argmax_classifier #(
  parameter int NUM_CLASSES  = 10,
  parameter int OUTPUT_WIDTH = 26,
  parameter int CLASS_WIDTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CLASSES*OUTPUT_WIDTH-1:0] IN_SCORES,
  input  logic [NUM_CLASSES-1:0]              in_done,
  output logic [CLASS_WIDTH-1:0]              CLASS,
  output logic [OUTPUT_WIDTH-1:0]             MAX_SCORE,
  output logic                                valid,
  output logic                                busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_CLASSES - 1);

  state_t                          state;
  logic signed [OUTPUT_WIDTH-1:0]  bank [NUM_CLASSES];
  logic signed [OUTPUT_WIDTH-1:0]  best;
  logic signed [OUTPUT_WIDTH-1:0]  cand;
  logic signed [OUTPUT_WIDTH-1:0]  nxt_best;
  logic [CLASS_WIDTH-1:0]          idx;
  logic [CLASS_WIDTH-1:0]          best_idx;
  logic [CLASS_WIDTH-1:0]          nxt_idx;
  logic                            all_done;
  logic                            all_done_q;
  logic                            start;
  logic                            last;

  assign all_done = &in_done;
  assign start    = all_done & ~all_done_q;
  assign cand     = bank[idx];
  assign last     = (idx == LAST_IDX);

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    nxt_best = best;
    nxt_idx  = best_idx;
    if (cand > best) begin
      nxt_best = cand;
      nxt_idx  = idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      best       <= '0;
      best_idx   <= '0;
      all_done_q <= 1'b0;
      CLASS      <= '0;
      MAX_SCORE  <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        bank[k] <= '0;
      end
    end else begin
      all_done_q <= all_done;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
              bank[k] <= IN_SCORES[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
            end
            best     <= IN_SCORES[OUTPUT_WIDTH-1:0];
            best_idx <= '0;
            idx      <= CLASS_WIDTH'(1);
            valid    <= 1'b0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          best     <= nxt_best;
          best_idx <= nxt_idx;
          if (last) begin
            CLASS     <= nxt_idx;
            MAX_SCORE <= nxt_best;
            valid     <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            idx <= idx + CLASS_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
